// File: rtl/ysyx_22040895_ifetch_bridge.sv
// ----------------------------------------------------------------------------
// ysyx_22040895_ifetch_bridge
//
// Turns single instruction-fetch requests from the core into one AXI4-Lite
// read. It returns the 32-bit instruction selected from the 64-bit beat,
// or an error for any of these cases:
//   - a misaligned PC,
//   - a non-OKAY response,
//   - a handshake that does not complete within TIMEOUT cycles.
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid_i/ready_o   : fetch request handshake, req_addr_i = PC
//   inst_valid_o/ready_i  : response handshake, inst_o / err_o payload
//   araddr_o/arvalid_o/arready_i          : AXI4-Lite read address channel
//   rdata_i/rresp_i/rvalid_i/rready_o     : AXI4-Lite read data channel
//   fetch_cnt_o           : completed response handshakes (wraps)
//
// The FSM is one-hot. Each handshake output is a single state bit, so no
// input can reach those outputs combinationally.
// ----------------------------------------------------------------------------
module ysyx_22040895_ifetch_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic [63:0] req_addr_i,
    output logic        req_ready_o,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic        err_o,
    input  logic        inst_ready_i,
    output logic [63:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [63:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [31:0] fetch_cnt_o
);

    localparam logic [3:0] S_IDLE = 4'b0001;
    localparam logic [3:0] S_AR   = 4'b0010;
    localparam logic [3:0] S_R    = 4'b0100;
    localparam logic [3:0] S_RESP = 4'b1000;

    // The counter holds k-1 during the k-th cycle of a wait. The wait is
    // abandoned at the end of the TIMEOUT-th cycle, when the counter steps
    // to TIMEOUT.
    localparam logic [31:0] TMO_LAST = (TIMEOUT == 0) ? 32'd0 : (32'(TIMEOUT) - 32'd1);

    logic [3:0]  state_q,     state_d;
    logic [63:2] addr_q,      addr_d;
    logic [31:0] inst_q,      inst_d;
    logic        err_q,       err_d;
    logic [31:0] tmo_q,       tmo_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        tmo_hit_s;

    assign tmo_hit_s = (tmo_q >= TMO_LAST);

    // Next-state, payload capture, timeout counting and fetch counting.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        inst_d      = inst_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        fetch_cnt_d = fetch_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d = req_addr_i[63:2];
                    if (req_addr_i[1:0] != 2'b00) begin
                        // Misaligned PC: skip the bus entirely.
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        inst_d  = 32'h0000_0000;
                    end else begin
                        state_d = S_AR;
                        tmo_d   = 32'd0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AR: begin
                // A handshake wins over a timeout in the same cycle.
                if (arready_i) begin
                    state_d = S_R;
                    tmo_d   = 32'd0;
                end else if (tmo_hit_s) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    inst_d  = 32'h0000_0000;
                    tmo_d   = tmo_q + 32'd1;
                end else begin
                    tmo_d   = tmo_q + 32'd1;
                end
            end
            S_R: begin
                if (rvalid_i) begin
                    state_d = S_RESP;
                    if (rresp_i != 2'b00) begin
                        err_d  = 1'b1;
                        inst_d = 32'h0000_0000;
                    end else begin
                        err_d  = 1'b0;
                        inst_d = addr_q[2] ? rdata_i[63:32] : rdata_i[31:0];
                    end
                end else if (tmo_hit_s) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    inst_d  = 32'h0000_0000;
                    tmo_d   = tmo_q + 32'd1;
                end else begin
                    tmo_d   = tmo_q + 32'd1;
                end
            end
            S_RESP: begin
                if (inst_ready_i) begin
                    state_d     = S_IDLE;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                end else begin
                    state_d     = S_RESP;
                end
            end
            default: begin
                // A corrupted one-hot code falls back to a clean idle.
                state_d = S_IDLE;
            end
        endcase
    end

    // State and payload registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= 62'd0;
            inst_q      <= 32'h0000_0000;
            err_q       <= 1'b0;
            tmo_q       <= 32'd0;
            fetch_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            inst_q      <= inst_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign req_ready_o  = state_q[0];
    assign arvalid_o    = state_q[1];
    assign rready_o     = state_q[2];
    assign inst_valid_o = state_q[3];
    assign araddr_o     = {addr_q[63:3], 3'b000};
    assign inst_o       = inst_q;
    assign err_o        = err_q;
    assign fetch_cnt_o  = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_22040895_ifetch_bridge.sv
// ----------------------------------------------------------------------------
// Scoreboard bench for ysyx_22040895_ifetch_bridge (TIMEOUT = 8).
// The stimulus pushes the expected {inst, err} for each fetch. A monitor
// pops and compares it whenever the response handshake is visible.
// ----------------------------------------------------------------------------
module tb_ysyx_22040895_ifetch_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic [63:0] req_addr_i;
    logic        req_ready_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic        err_o;
    logic        inst_ready_i;
    logic [63:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [63:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] fetch_cnt_o;

    ysyx_22040895_ifetch_bridge #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .err_o(err_o), .inst_ready_i(inst_ready_i),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ar_hs    = 0;
    int          ar_cyc   = 0;
    int          rr_cyc   = 0;
    logic [63:0] ar_addr_last = 64'd0;
    logic [31:0] exp_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bus activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (arvalid_o) ar_cyc++;
            if (arvalid_o && arready_i) begin
                ar_hs++;
                ar_addr_last = araddr_o;
            end
            if (rready_o) rr_cyc++;
        end
    end

    // Response monitor: compares every response handshake with the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && inst_valid_o && inst_ready_i) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_response", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_inst", {32'd0, inst_o}, {32'd0, e.inst});
                chk("sb_err", {63'd0, err_o}, {63'd0, e.err});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the request handshake.
    task automatic issue(input logic [63:0] addr);
        int n = 0;
        while (!req_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_before_issue", {63'd0, req_ready_o}, 64'd1);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
    endtask

    // Waits (bounded) for inst_valid_o. When exp_lat > 0 it also checks the
    // latency in cycles after the handshake. It returns at posedge+1 after
    // the first valid cycle.
    task automatic wait_valid(input string name, input int exp_lat);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = inst_valid_o;
        end
        chk({name, "_valid_seen"}, {63'd0, seen}, 64'd1);
        if (exp_lat > 0) chk({name, "_latency"}, n, exp_lat);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"},  {63'd0, req_ready_o},  64'd1);
        chk({tag, "_arvalid"},    {63'd0, arvalid_o},    64'd0);
        chk({tag, "_rready"},     {63'd0, rready_o},     64'd0);
        chk({tag, "_inst_valid"}, {63'd0, inst_valid_o}, 64'd0);
        chk({tag, "_inst"},       {32'd0, inst_o},       64'd0);
        chk({tag, "_err"},        {63'd0, err_o},        64'd0);
        chk({tag, "_araddr"},     araddr_o,              64'd0);
        chk({tag, "_fetch_cnt"},  {32'd0, fetch_cnt_o},  64'd0);
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0;
        rst          = 1'b1;
        req_valid_i  = 1'b0;
        req_addr_i   = 64'd0;
        inst_ready_i = 1'b1;
        arready_i    = 1'b1;
        rvalid_i     = 1'b1;
        rdata_i      = 64'd0;
        rresp_i      = 2'b00;
        exp_cnt      = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Aligned fetch, upper word, minimum latency
        rdata_i = 64'h0010_0093_0000_0413;
        sb_q.push_back('{inst: 32'h0010_0093, err: 1'b0});
        issue(64'h0000_0000_8000_0004);
        wait_valid("aligned", 3);
        exp_cnt++;
        chk("aligned_fetch_cnt", {32'd0, fetch_cnt_o}, {32'd0, exp_cnt});
        chk("aligned_araddr", ar_addr_last, 64'h0000_0000_8000_0000);

        // Backpressure on AR, then on the response
        arready_i    = 1'b0;
        inst_ready_i = 1'b0;
        rdata_i      = 64'hAAAA_5555_1234_5678;
        b0           = ar_hs;
        sb_q.push_back('{inst: 32'h1234_5678, err: 1'b0});
        issue(64'h0000_0000_8000_0010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_arvalid_hold", {63'd0, arvalid_o}, 64'd1);
            chk("bp_araddr_hold", araddr_o, 64'h0000_0000_8000_0010);
            @(posedge clk); #1;
        end
        arready_i = 1'b1;
        wait_valid("bp", -1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_inst_valid_hold", {63'd0, inst_valid_o}, 64'd1);
            chk("bp_inst_hold", {32'd0, inst_o}, 64'h0000_0000_1234_5678);
            @(posedge clk); #1;
        end
        inst_ready_i = 1'b1;
        @(posedge clk); #1;
        exp_cnt++;
        chk("bp_fetch_cnt", {32'd0, fetch_cnt_o}, {32'd0, exp_cnt});
        chk("bp_ar_handshakes", ar_hs - b0, 1);
        chk("bp_back_to_idle", {63'd0, req_ready_o}, 64'd1);

        // Bus error response
        rresp_i = 2'b10;
        rdata_i = 64'hDEAD_BEEF_CAFE_F00D;
        sb_q.push_back('{inst: 32'h0000_0000, err: 1'b1});
        issue(64'h0000_0000_8000_0008);
        wait_valid("buserr", 3);
        exp_cnt++;
        chk("buserr_fetch_cnt", {32'd0, fetch_cnt_o}, {32'd0, exp_cnt});
        rresp_i = 2'b00;

        // Misaligned PC: no AR at all
        b0 = ar_cyc;
        sb_q.push_back('{inst: 32'h0000_0000, err: 1'b1});
        issue(64'h0000_0000_8000_0002);
        wait_valid("misalign", 1);
        exp_cnt++;
        chk("misalign_fetch_cnt", {32'd0, fetch_cnt_o}, {32'd0, exp_cnt});
        chk("misalign_no_arvalid", ar_cyc - b0, 0);

        // Timeout in R: 8 R cycles, then an error response
        rvalid_i = 1'b0;
        b0       = rr_cyc;
        sb_q.push_back('{inst: 32'h0000_0000, err: 1'b1});
        issue(64'h0000_0000_8000_0004);
        wait_valid("timeout", 10);
        exp_cnt++;
        chk("timeout_rready_cycles", rr_cyc - b0, 8);
        chk("timeout_rready_dropped", {63'd0, rready_o}, 64'd0);
        chk("timeout_fetch_cnt", {32'd0, fetch_cnt_o}, {32'd0, exp_cnt});

        // rvalid in the 8th R cycle beats the timeout
        rdata_i = 64'h0BAD_C0DE_00A0_0513;
        sb_q.push_back('{inst: 32'h00A0_0513, err: 1'b0});
        issue(64'h0000_0000_8000_0008);
        repeat (8) begin
            @(posedge clk); #1;
        end
        rvalid_i = 1'b1;
        wait_valid("race", 2);
        exp_cnt++;
        chk("race_fetch_cnt", {32'd0, fetch_cnt_o}, {32'd0, exp_cnt});

        // Reset in the middle of R
        rvalid_i = 1'b0;
        issue(64'h0000_0000_8000_0020);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midr_in_r", {63'd0, rready_o}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("midr_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        exp_cnt  = 32'd0;
        rvalid_i = 1'b1;
        rdata_i  = 64'h0010_0093_0000_0413;
        sb_q.push_back('{inst: 32'h0000_0413, err: 1'b0});
        issue(64'h0000_0000_8000_0000);
        wait_valid("postrst", 3);
        exp_cnt++;
        chk("postrst_fetch_cnt", {32'd0, fetch_cnt_o}, {32'd0, exp_cnt});

        // Fetch counter wrap
        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt_q;
        chk("wrap_preset", {32'd0, fetch_cnt_o}, 64'h0000_0000_FFFF_FFFF);
        sb_q.push_back('{inst: 32'h0010_0093, err: 1'b0});
        issue(64'h0000_0000_8000_0004);
        wait_valid("wrap", 3);
        chk("wrap_fetch_cnt", {32'd0, fetch_cnt_o}, 64'd0);

        repeat (2) @(posedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
